mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the native valid/ready memory bus: valid, addr, wdata, wstrb, ready, rdata.
- Shares the on-chip firmware RAM and peripheral decode between the picorv32 core (master 0) and a DMA/loader port (master 1).
- Grant is registered and held for the whole transaction.
- Round-robin fairness, with a configurable tie-break on the first request after reset.

---
 rtl/mem_bus_pkg.sv | 12 +
 rtl/rr_pick2.sv | 11 +
 rtl/mem_bus_arbiter.sv | 85 ++++++++
 tb/tb_mem_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared states, grant encodings and timeout data for the memory bus arbiter
package mem_bus_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0 = 2'b01;
  localparam logic [1:0] GNT_M1 = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker, one-hot winner, ties go to the master other than last
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);
  always_comb begin
    win[0] = req[0] & (~req[1] | last);
    win[1] = req[1] & (~req[0] | ~last);
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master valid/ready bus arbiter with registered round-robin grant, optional ARB_TIMEOUT_EN watchdog
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RESET_PRIO = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant
`ifdef ARB_TIMEOUT_EN
  ,output logic               timeout_err
`endif
);
  arb_state_t state, state_n;
  logic last_srv, pick_last, own0, own1, s_valid_raw, fin, to_hit;
  logic [1:0] win;
  assign own0 = state == ARB_OWN0;
  assign own1 = state == ARB_OWN1;
  assign s_valid_raw = (own0 & m0_valid) | (own1 & m1_valid);
  assign pick_last = own0 ? 1'b0 : own1 ? 1'b1 : last_srv;
  rr_pick2 u_pick (
    .req ({m1_valid, m0_valid}),
    .last(pick_last),
    .win (win)
  );
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign to_hit = s_valid_raw & ~s_ready & (cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (state != ARB_IDLE && !fin && state_n == state) ? cnt + 1'b1 : '0;
      timeout_err <= timeout_err | to_hit;
    end
  end
`else
  assign to_hit = TIMEOUT_CYCLES < 0;
`endif
  always_comb begin
    s_valid = s_valid_raw & ~to_hit;
    s_addr = own0 ? m0_addr : own1 ? m1_addr : '0;
    s_wdata = own0 ? m0_wdata : own1 ? m1_wdata : '0;
    s_wstrb = own0 ? m0_wstrb : own1 ? m1_wstrb : '0;
    fin = (s_valid & s_ready) | to_hit;
    m0_ready = own0 & fin;
    m1_ready = own1 & fin;
    m0_rdata = !own0 ? '0 : to_hit ? DATA_W'(TIMEOUT_RDATA) : s_rdata;
    m1_rdata = !own1 ? '0 : to_hit ? DATA_W'(TIMEOUT_RDATA) : s_rdata;
    grant = own0 ? GNT_M0 : own1 ? GNT_M1 : GNT_NONE;
    state_n = (state == ARB_IDLE || fin) ? arb_state_t'(win) : s_valid_raw ? state : ARB_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      last_srv <= RESET_PRIO == 0;
    end else begin
      state <= state_n;
      last_srv <= fin ? own1 : last_srv;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter with directed master/slave stimulus
module tb_mem_bus_arbiter;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  typedef struct packed {
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } tr_t;
  logic clk = 1'b0, reset = 1'b1;
  logic m0_valid = 1'b0, m1_valid = 1'b0, m0_ready, m1_ready;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, m0_rdata, m1_rdata;
  logic [3:0] m0_wstrb = '0, m1_wstrb = '0, s_wstrb;
  logic s_valid, s_ready = 1'b0;
  logic [31:0] s_addr, s_wdata, s_rdata = '0;
  logic [1:0] grant;
`ifdef ARB_TIMEOUT_EN
  logic timeout_err;
`endif
  int checks = 0, errors = 0, slv_delay = 2, scnt = 0;
  tr_t exp_q[$];
  tr_t e;
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RESET_PRIO(0), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant)
`ifdef ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask
  task automatic push(input logic [1:0] g, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] r);
    tr_t t;
    t.gnt = g;
    t.addr = a;
    t.wdata = d;
    t.wstrb = s;
    t.rdata = r;
    exp_q.push_back(t);
  endtask
  task automatic m_req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end else begin
      m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end
  endtask
  task automatic m_drop(input int m);
    if (m == 0) begin
      m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    end else begin
      m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    end
  endtask
  task automatic m_wait(input int m);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? m0_ready : m1_ready;
    end
    if (!got) chk(m == 0 ? "wait_m0_ready" : "wait_m1_ready", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    m_drop(m);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    if (s_ready) begin
      s_ready = 1'b0;
      scnt = 0;
    end else if (s_valid) begin
      if (scnt == slv_delay) s_ready = 1'b1;
      else scnt++;
    end else scnt = 0;
  end
  always @(negedge clk) begin
    if (!reset && (m0_ready || m1_ready)) begin
      if (exp_q.size() == 0) chk("sb_unexpected_ready", {62'd0, m1_ready, m0_ready}, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_grant", {62'd0, grant}, {62'd0, e.gnt});
        chk("sb_ready", {62'd0, m1_ready, m0_ready}, {62'd0, e.gnt});
        chk("sb_addr", {32'd0, s_addr}, {32'd0, e.addr});
        chk("sb_wdata", {32'd0, s_wdata}, {32'd0, e.wdata});
        chk("sb_wstrb", {60'd0, s_wstrb}, {60'd0, e.wstrb});
        chk("sb_rdata", {32'd0, e.gnt[0] ? m0_rdata : m1_rdata}, {32'd0, e.rdata});
        chk("sb_other_rdata", {32'd0, e.gnt[0] ? m1_rdata : m0_rdata}, 64'd0);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    slv_delay = 2;
    s_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    push(2'b01, 32'h10, 32'h0, 4'h0, 32'h1234_5678);
    m_req(0, 32'h10, 32'h0, 4'h0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_grant", {62'd0, grant}, 64'd0);
      chk("rst_s_valid", {63'd0, s_valid}, 64'd0);
      chk("rst_m0_ready", {63'd0, m0_ready}, 64'd0);
`ifdef ARB_TIMEOUT_EN
      chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
`endif
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("release_grant", {62'd0, grant}, 64'd0);
    @(negedge clk);
    chk("first_grant", {62'd0, grant}, 64'd1);
    chk("first_s_valid", {63'd0, s_valid}, 64'd1);
    chk("first_s_addr", {32'd0, s_addr}, 64'h10);
    m_wait(0);
    idle(3);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    slv_delay = 1;
    s_rdata = 32'hCAFE_0001;
    push(2'b01, 32'h100, 32'hA000_0000, 4'hF, 32'hCAFE_0001);
    push(2'b10, 32'h200, 32'hB000_0000, 4'hF, 32'hCAFE_0001);
    push(2'b01, 32'h104, 32'hA000_0001, 4'hF, 32'hCAFE_0001);
    push(2'b10, 32'h204, 32'hB000_0001, 4'hF, 32'hCAFE_0001);
    fork
      for (int i = 0; i < 2; i++) begin
        m_req(0, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
        m_wait(0);
        idle(1);
      end
      for (int j = 0; j < 2; j++) begin
        m_req(1, 32'h200 + 32'(4 * j), 32'hB000_0000 + 32'(j), 4'hF);
        m_wait(1);
        idle(1);
      end
    join
    idle(3);
    slv_delay = 10;
    s_rdata = 32'h0BAD_F00D;
    push(2'b10, 32'h300, 32'h0, 4'h0, 32'h0BAD_F00D);
    push(2'b01, 32'h40, 32'h0, 4'h0, 32'h0BAD_F00D);
    m_req(1, 32'h300, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    m_req(0, 32'h40, 32'h0, 4'h0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("stall_m0_ready", {63'd0, m0_ready}, 64'd0);
      chk("stall_s_addr", {32'd0, s_addr}, 64'h300);
      chk("stall_grant", {62'd0, grant}, 64'd2);
    end
    m_wait(1);
    @(negedge clk);
    chk("after_stall_grant", {62'd0, grant}, 64'd1);
    m_wait(0);
    idle(3);
    push(2'b01, 32'h50, 32'h0, 4'h0, 32'h0BAD_F00D);
    m_req(1, 32'h500, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    m_req(0, 32'h50, 32'h0, 4'h0);
    @(negedge clk);
    chk("drop_own1", {62'd0, grant}, 64'd2);
    @(posedge clk);
    #1;
    m_drop(1);
    @(negedge clk);
    chk("drop_s_valid", {63'd0, s_valid}, 64'd0);
    chk("drop_m1_ready", {63'd0, m1_ready}, 64'd0);
    @(negedge clk);
    chk("drop_idle", {62'd0, grant}, 64'd0);
    @(negedge clk);
    chk("drop_m0_granted", {62'd0, grant}, 64'd1);
    m_wait(0);
    idle(3);
    slv_delay = 1;
    s_rdata = 32'h5555_AAAA;
    m_req(1, 32'h600, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    m_drop(1);
    @(posedge clk);
    #1;
    push(2'b10, 32'h610, 32'h0, 4'h0, 32'h5555_AAAA);
    push(2'b01, 32'h60, 32'h0, 4'h0, 32'h5555_AAAA);
    fork
      begin m_req(0, 32'h60, 32'h0, 4'h0); m_wait(0); end
      begin m_req(1, 32'h610, 32'h0, 4'h0); m_wait(1); end
    join
    idle(3);
`ifdef ARB_TIMEOUT_EN
    slv_delay = 1000;
    s_rdata = 32'h0;
    push(2'b01, 32'h70, 32'h0, 4'h0, 32'hDEAD_BEEF);
    m_req(0, 32'h70, 32'h0, 4'h0);
    @(posedge clk);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("to_early_ready", {63'd0, m0_ready}, 64'd0);
    end
    @(negedge clk);
    chk("to_ready", {63'd0, m0_ready}, 64'd1);
    chk("to_rdata", {32'd0, m0_rdata}, 64'hDEAD_BEEF);
    chk("to_s_valid", {63'd0, s_valid}, 64'd0);
    @(posedge clk);
    #1;
    m_drop(0);
    @(negedge clk);
    chk("to_err_set", {63'd0, timeout_err}, 64'd1);
    repeat (4) @(negedge clk);
    chk("to_err_sticky", {63'd0, timeout_err}, 64'd1);
    chk("to_idle", {62'd0, grant}, 64'd0);
`endif
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
